xfcp_port_arb: RTL and testbench

Packet-level arbiter that shares one downstream XFCP module tree among several upstream XFCP links (UART, UDP/Ethernet, MGT) inside `fpga_core`. It grants one upstream port at a time and forwards that port's request packet downstream. It then holds the grant until the matching response packet has been routed back to the same port, or until a timeout expires. Arbitration is round-robin at packet granularity, with one outstanding transaction at a time.

---
 rtl/xfcp_port_arb_if.sv | 52 +++++
 rtl/xfcp_port_arb.sv | 113 +++++++++++
 tb/tb_xfcp_port_arb.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xfcp_port_arb_if.sv
// Bundle of upstream (per-port, flattened) and downstream XFCP AXI-stream links around the port arbiter.
interface xfcp_port_arb_if #(
  parameter int unsigned PORTS = 3
);
  logic [PORTS*8-1:0] up_xfcp_in_tdata;
  logic [PORTS-1:0]   up_xfcp_in_tvalid;
  logic [PORTS-1:0]   up_xfcp_in_tready;
  logic [PORTS-1:0]   up_xfcp_in_tlast;
  logic [PORTS-1:0]   up_xfcp_in_tuser;

  logic [PORTS*8-1:0] up_xfcp_out_tdata;
  logic [PORTS-1:0]   up_xfcp_out_tvalid;
  logic [PORTS-1:0]   up_xfcp_out_tready;
  logic [PORTS-1:0]   up_xfcp_out_tlast;
  logic [PORTS-1:0]   up_xfcp_out_tuser;

  logic [7:0]         down_xfcp_out_tdata;
  logic               down_xfcp_out_tvalid;
  logic               down_xfcp_out_tready;
  logic               down_xfcp_out_tlast;
  logic               down_xfcp_out_tuser;

  logic [7:0]         down_xfcp_in_tdata;
  logic               down_xfcp_in_tvalid;
  logic               down_xfcp_in_tready;
  logic               down_xfcp_in_tlast;
  logic               down_xfcp_in_tuser;

  // Arbiter side
  modport slave (
    input  up_xfcp_in_tdata, up_xfcp_in_tvalid, up_xfcp_in_tlast, up_xfcp_in_tuser,
    output up_xfcp_in_tready,
    output up_xfcp_out_tdata, up_xfcp_out_tvalid, up_xfcp_out_tlast, up_xfcp_out_tuser,
    input  up_xfcp_out_tready,
    output down_xfcp_out_tdata, down_xfcp_out_tvalid, down_xfcp_out_tlast, down_xfcp_out_tuser,
    input  down_xfcp_out_tready,
    input  down_xfcp_in_tdata, down_xfcp_in_tvalid, down_xfcp_in_tlast, down_xfcp_in_tuser,
    output down_xfcp_in_tready
  );

  // Environment side: upstream links and downstream module tree
  modport master (
    output up_xfcp_in_tdata, up_xfcp_in_tvalid, up_xfcp_in_tlast, up_xfcp_in_tuser,
    input  up_xfcp_in_tready,
    input  up_xfcp_out_tdata, up_xfcp_out_tvalid, up_xfcp_out_tlast, up_xfcp_out_tuser,
    output up_xfcp_out_tready,
    input  down_xfcp_out_tdata, down_xfcp_out_tvalid, down_xfcp_out_tlast, down_xfcp_out_tuser,
    output down_xfcp_out_tready,
    output down_xfcp_in_tdata, down_xfcp_in_tvalid, down_xfcp_in_tlast, down_xfcp_in_tuser,
    input  down_xfcp_in_tready
  );
endinterface

// File: rtl/xfcp_port_arb.sv
// Round-robin packet arbiter sharing one downstream XFCP tree among PORTS upstream links,
// one outstanding request/response transaction at a time with a response timeout.
module xfcp_port_arb #(
  parameter int unsigned PORTS     = 3,
  parameter int unsigned TIMEOUT   = 65535,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  xfcp_port_arb_if.slave  bus
);

  localparam int unsigned IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_FWD_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT_RESP = 2'd2;
  localparam logic [1:0] S_FWD_RESP  = 2'd3;

  // Count value in the last WAIT_RESP cycle before the transaction is abandoned
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [1:0]           state, state_nxt;
  logic [IDX_W-1:0]     grant_idx, grant_nxt, cand;
  logic [TIMEOUT_W-1:0] cnt, cnt_nxt;
  logic                 found;

  // grant_idx doubles as the round-robin pointer: the scan starts just after it
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      grant_idx <= IDX_W'(PORTS - 1);
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
      cnt       <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_idx;
    cnt_nxt   = cnt;
    cand      = grant_idx;
    found     = 1'b0;

    bus.up_xfcp_in_tready    = '0;
    bus.up_xfcp_out_tdata    = '0;
    bus.up_xfcp_out_tvalid   = '0;
    bus.up_xfcp_out_tlast    = '0;
    bus.up_xfcp_out_tuser    = '0;
    bus.down_xfcp_out_tdata  = '0;
    bus.down_xfcp_out_tvalid = 1'b0;
    bus.down_xfcp_out_tlast  = 1'b0;
    bus.down_xfcp_out_tuser  = 1'b0;
    // Orphan responses are drained whenever no response is being awaited
    bus.down_xfcp_in_tready  = (state == S_IDLE) || (state == S_FWD_REQ);

    for (int i = 0; i < int'(PORTS); i++) begin
      if (grant_idx == IDX_W'(i)) begin
        if (state == S_FWD_REQ) begin
          bus.down_xfcp_out_tdata  = bus.up_xfcp_in_tdata[i*8 +: 8];
          bus.down_xfcp_out_tvalid = bus.up_xfcp_in_tvalid[i];
          bus.down_xfcp_out_tlast  = bus.up_xfcp_in_tlast[i];
          bus.down_xfcp_out_tuser  = bus.up_xfcp_in_tuser[i];
          bus.up_xfcp_in_tready[i] = bus.down_xfcp_out_tready;
        end else if (state == S_FWD_RESP) begin
          bus.up_xfcp_out_tdata[i*8 +: 8] = bus.down_xfcp_in_tdata;
          bus.up_xfcp_out_tvalid[i]       = bus.down_xfcp_in_tvalid;
          bus.up_xfcp_out_tlast[i]        = bus.down_xfcp_in_tlast;
          bus.up_xfcp_out_tuser[i]        = bus.down_xfcp_in_tuser;
          bus.down_xfcp_in_tready         = bus.up_xfcp_out_tready[i];
        end
      end
    end

    case (state)
      S_IDLE: begin
        for (int k = 1; k <= int'(PORTS); k++) begin
          cand = IDX_W'((int'(grant_idx) + k) % int'(PORTS));
          if (!found && bus.up_xfcp_in_tvalid[cand]) begin
            found     = 1'b1;
            grant_nxt = cand;
          end
        end
        if (found) state_nxt = S_FWD_REQ;
      end
      S_FWD_REQ: begin
        if (bus.down_xfcp_out_tvalid && bus.down_xfcp_out_tready && bus.down_xfcp_out_tlast) begin
          cnt_nxt   = '0;
          state_nxt = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        // A response arriving in the final cycle still takes priority over the timeout
        if (bus.down_xfcp_in_tvalid) begin
          state_nxt = S_FWD_RESP;
        end else if (cnt == TMO_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + TIMEOUT_W'(1);
        end
      end
      S_FWD_RESP: begin
        if (bus.down_xfcp_in_tvalid && bus.down_xfcp_in_tready && bus.down_xfcp_in_tlast)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_xfcp_port_arb.sv
// Directed bench for xfcp_port_arb: negedge monitor records every transferred beat, scenario tasks compare.
module tb_xfcp_port_arb;

  localparam int unsigned PORTS     = 3;
  localparam int unsigned TIMEOUT   = 16;
  localparam int unsigned TIMEOUT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xfcp_port_arb_if #(.PORTS(PORTS)) bus ();

  xfcp_port_arb #(.PORTS(PORTS), .TIMEOUT(TIMEOUT), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         port;
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  beat_t            req_q[$];
  beat_t            resp_q[$];
  int               grant_q[$];
  int               total = 0;
  int               bad = 0;
  int               req_pkts = 0;
  int               dn_acc = 0;
  logic [PORTS-1:0] vseen = '0;
  bit               in_req = 1'b0;
  int               dn_mode = 0;
  bit               bp_en = 1'b0;

  // Ready drivers: 0 = always ready, 1 = random, 2 = held low
  initial begin
    bus.down_xfcp_out_tready = 1'b1;
    bus.up_xfcp_out_tready   = '1;
    forever begin
      @(posedge clk); #1;
      case (dn_mode)
        0:       bus.down_xfcp_out_tready = 1'b1;
        1:       bus.down_xfcp_out_tready = 1'($urandom % 2);
        default: bus.down_xfcp_out_tready = 1'b0;
      endcase
      bus.up_xfcp_out_tready = bp_en ? PORTS'($urandom) : '1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        in_req = 1'b0;
      end else begin
        if (bus.down_xfcp_out_tvalid && bus.down_xfcp_out_tready) begin
          int p;
          p = -1;
          for (int i = 0; i < int'(PORTS); i++) if (bus.up_xfcp_in_tready[i]) p = i;
          if (!in_req) grant_q.push_back(p);
          req_q.push_back('{p, bus.down_xfcp_out_tdata, bus.down_xfcp_out_tlast, bus.down_xfcp_out_tuser});
          in_req = !bus.down_xfcp_out_tlast;
          if (bus.down_xfcp_out_tlast) req_pkts++;
        end
        for (int i = 0; i < int'(PORTS); i++)
          if (bus.up_xfcp_out_tvalid[i] && bus.up_xfcp_out_tready[i])
            resp_q.push_back('{i, bus.up_xfcp_out_tdata[i*8 +: 8], bus.up_xfcp_out_tlast[i], bus.up_xfcp_out_tuser[i]});
        if (bus.down_xfcp_in_tvalid && bus.down_xfcp_in_tready) dn_acc++;
      end
      vseen = vseen | bus.up_xfcp_out_tvalid;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=no_finish want=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear();
    req_q.delete();
    resp_q.delete();
    grant_q.delete();
    vseen = '0;
  endtask

  task automatic send_req(input int p, input int len, input logic [7:0] base, input logic user_last);
    for (int b = 0; b < len; b++) begin
      int t;
      bus.up_xfcp_in_tdata[p*8 +: 8] = base + 8'(b);
      bus.up_xfcp_in_tvalid[p] = 1'b1;
      bus.up_xfcp_in_tlast[p]  = (b == len - 1);
      bus.up_xfcp_in_tuser[p]  = user_last && (b == len - 1);
      t = 0;
      @(negedge clk);
      while (!bus.up_xfcp_in_tready[p] && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) begin
        total++; bad++;
        $display("FAIL req_handshake port=%0d got=timeout want=ready", p);
      end
      tick();
    end
    bus.up_xfcp_in_tvalid[p] = 1'b0;
    bus.up_xfcp_in_tlast[p]  = 1'b0;
    bus.up_xfcp_in_tuser[p]  = 1'b0;
  endtask

  task automatic send_resp(input int len, input logic [7:0] base, input logic user_last);
    for (int b = 0; b < len; b++) begin
      int t;
      bus.down_xfcp_in_tdata  = base + 8'(b);
      bus.down_xfcp_in_tvalid = 1'b1;
      bus.down_xfcp_in_tlast  = (b == len - 1);
      bus.down_xfcp_in_tuser  = user_last && (b == len - 1);
      t = 0;
      @(negedge clk);
      while (!bus.down_xfcp_in_tready && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) begin
        total++; bad++;
        $display("FAIL resp_handshake got=timeout want=ready");
      end
      tick();
    end
    bus.down_xfcp_in_tvalid = 1'b0;
    bus.down_xfcp_in_tlast  = 1'b0;
    bus.down_xfcp_in_tuser  = 1'b0;
  endtask

  // Returns at negedge+1 of the cycle whose request tlast beat transfers at the next edge
  task automatic wait_req(input int n);
    int t;
    t = 0;
    do begin
      @(negedge clk); #1;
      t++;
    end while (req_pkts < n && t < 2000);
    if (req_pkts < n) begin
      total++; bad++;
      $display("FAIL wait_req got=%0d want=%0d", req_pkts, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.up_xfcp_in_tdata    = '0;
    bus.up_xfcp_in_tvalid   = '0;
    bus.up_xfcp_in_tlast    = '0;
    bus.up_xfcp_in_tuser    = '0;
    bus.down_xfcp_in_tdata  = '0;
    bus.down_xfcp_in_tvalid = 1'b0;
    bus.down_xfcp_in_tlast  = 1'b0;
    bus.down_xfcp_in_tuser  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total += 8;
    if (bus.up_xfcp_in_tready !== 3'b000) begin bad++; $display("FAIL rst_up_in_tready got=%b want=000", bus.up_xfcp_in_tready); end
    if (bus.up_xfcp_out_tvalid !== 3'b000) begin bad++; $display("FAIL rst_up_out_tvalid got=%b want=000", bus.up_xfcp_out_tvalid); end
    if (bus.up_xfcp_out_tlast !== 3'b000) begin bad++; $display("FAIL rst_up_out_tlast got=%b want=000", bus.up_xfcp_out_tlast); end
    if (bus.up_xfcp_out_tuser !== 3'b000) begin bad++; $display("FAIL rst_up_out_tuser got=%b want=000", bus.up_xfcp_out_tuser); end
    if (bus.down_xfcp_out_tvalid !== 1'b0) begin bad++; $display("FAIL rst_down_out_tvalid got=%b want=0", bus.down_xfcp_out_tvalid); end
    if (bus.down_xfcp_out_tlast !== 1'b0) begin bad++; $display("FAIL rst_down_out_tlast got=%b want=0", bus.down_xfcp_out_tlast); end
    if (bus.down_xfcp_out_tuser !== 1'b0) begin bad++; $display("FAIL rst_down_out_tuser got=%b want=0", bus.down_xfcp_out_tuser); end
    if (bus.down_xfcp_in_tready !== 1'b1) begin bad++; $display("FAIL rst_down_in_tready got=%b want=1", bus.down_xfcp_in_tready); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    int base;
    clear();
    base = req_pkts;
    fork
      send_req(0, 4, 8'hA0, 1'b0);
      begin wait_req(base + 1); tick(); send_resp(6, 8'hC0, 1'b0); end
    join
    repeat (3) tick();
    total++;
    if (req_q.size() !== 4) begin bad++; $display("FAIL basic_req_len got=%0d want=4", req_q.size()); end
    total++;
    if (resp_q.size() !== 6) begin bad++; $display("FAIL basic_resp_len got=%0d want=6", resp_q.size()); end
    while (req_q.size() < 4) req_q.push_back('{-1, 8'h00, 1'b0, 1'b0});
    while (resp_q.size() < 6) resp_q.push_back('{-1, 8'h00, 1'b0, 1'b0});
    for (int b = 0; b < 4; b++) begin
      total++;
      if (req_q[b].data !== 8'hA0 + 8'(b) || req_q[b].last !== (b == 3) || req_q[b].port != 0) begin
        bad++;
        $display("FAIL basic_req%0d got=%h/%b/p%0d want=%h/%b/p0", b, req_q[b].data, req_q[b].last, req_q[b].port, 8'hA0 + 8'(b), (b == 3));
      end
    end
    for (int b = 0; b < 6; b++) begin
      total++;
      if (resp_q[b].data !== 8'hC0 + 8'(b) || resp_q[b].last !== (b == 5) || resp_q[b].port != 0) begin
        bad++;
        $display("FAIL basic_resp%0d got=%h/%b/p%0d want=%h/%b/p0", b, resp_q[b].data, resp_q[b].last, resp_q[b].port, 8'hC0 + 8'(b), (b == 5));
      end
    end
    total++;
    if (vseen !== 3'b001) begin bad++; $display("FAIL basic_vseen got=%b want=001", vseen); end
  endtask

  task automatic test_round_robin();
    int base;
    int exp_g[4];
    exp_g = '{0, 1, 2, 0};
    do_reset();
    clear();
    base = req_pkts;
    fork
      begin send_req(0, 2, 8'h00, 1'b0); send_req(0, 1, 8'h03, 1'b0); end
      send_req(1, 1, 8'h10, 1'b0);
      send_req(2, 3, 8'h20, 1'b0);
      for (int k = 0; k < 4; k++) begin
        wait_req(base + k + 1);
        tick();
        send_resp(1, 8'h50 + 8'(k), 1'b0);
      end
    join
    repeat (2) tick();
    total++;
    if (grant_q.size() !== 4) begin bad++; $display("FAIL rr_grants got=%0d want=4", grant_q.size()); end
    while (grant_q.size() < 4) grant_q.push_back(-1);
    while (resp_q.size() < 4) resp_q.push_back('{-1, 8'h00, 1'b0, 1'b0});
    for (int k = 0; k < 4; k++) begin
      total++;
      if (grant_q[k] != exp_g[k]) begin bad++; $display("FAIL rr_grant%0d got=%0d want=%0d", k, grant_q[k], exp_g[k]); end
      total++;
      if (resp_q[k].port != exp_g[k] || resp_q[k].data !== 8'h50 + 8'(k) || resp_q[k].last !== 1'b1) begin
        bad++;
        $display("FAIL rr_resp%0d got=p%0d/%h want=p%0d/%h", k, resp_q[k].port, resp_q[k].data, exp_g[k], 8'h50 + 8'(k));
      end
    end
  endtask

  task automatic test_timeout();
    int base, a0, zc;
    clear();
    base = req_pkts;
    a0 = dn_acc;
    zc = 0;
    fork
      send_req(1, 3, 8'h40, 1'b0);
      begin repeat (5) tick(); send_req(2, 2, 8'h60, 1'b0); end
      begin
        wait_req(base + 1);
        dn_mode = 2;
        @(posedge clk);
        @(negedge clk);
        while (bus.down_xfcp_in_tready === 1'b0 && zc < 100) begin
          zc++;
          @(negedge clk);
        end
        total++;
        if (zc != 16) begin bad++; $display("FAIL tmo_wait_cycles got=%0d want=16", zc); end
        tick();
        for (int b = 0; b < 3; b++) begin
          bus.down_xfcp_in_tdata  = 8'h90 + 8'(b);
          bus.down_xfcp_in_tvalid = 1'b1;
          bus.down_xfcp_in_tlast  = (b == 2);
          @(negedge clk);
          total++;
          if (bus.down_xfcp_in_tready !== 1'b1) begin bad++; $display("FAIL tmo_drain_rdy%0d got=%b want=1", b, bus.down_xfcp_in_tready); end
          tick();
        end
        bus.down_xfcp_in_tvalid = 1'b0;
        bus.down_xfcp_in_tlast  = 1'b0;
        total++;
        if (resp_q.size() !== 0) begin bad++; $display("FAIL tmo_drain_leak got=%0d want=0", resp_q.size()); end
        dn_mode = 0;
      end
    join
    send_resp(2, 8'h70, 1'b1);
    repeat (3) tick();
    total++;
    if (dn_acc - a0 != 5) begin bad++; $display("FAIL tmo_dn_accepted got=%0d want=5", dn_acc - a0); end
    total++;
    if (resp_q.size() !== 2) begin bad++; $display("FAIL tmo_resp_len got=%0d want=2", resp_q.size()); end
    while (resp_q.size() < 2) resp_q.push_back('{-1, 8'h00, 1'b0, 1'b0});
    while (grant_q.size() < 2) grant_q.push_back(-1);
    total++;
    if (grant_q[0] != 1 || grant_q[1] != 2) begin bad++; $display("FAIL tmo_grants got=%0d,%0d want=1,2", grant_q[0], grant_q[1]); end
    total++;
    if (resp_q[1].port != 2 || resp_q[0].data !== 8'h70 || resp_q[1].data !== 8'h71 || resp_q[1].user !== 1'b1) begin
      bad++;
      $display("FAIL tmo_resp got=p%0d/%h/%h/u%b want=p2/70/71/u1", resp_q[1].port, resp_q[0].data, resp_q[1].data, resp_q[1].user);
    end
    total++;
    if (vseen !== 3'b100) begin bad++; $display("FAIL tmo_vseen got=%b want=100", vseen); end
  endtask

  task automatic test_timeout_edge();
    int base;
    clear();
    base = req_pkts;
    fork
      send_req(0, 1, 8'hB0, 1'b0);
      begin
        wait_req(base + 1);
        @(posedge clk);
        repeat (15) @(posedge clk);
        #1;
        send_resp(2, 8'hD0, 1'b0);
      end
    join
    repeat (2) tick();
    total++;
    if (req_q.size() !== 1) begin bad++; $display("FAIL edge_req_len got=%0d want=1", req_q.size()); end
    total++;
    if (resp_q.size() !== 2) begin bad++; $display("FAIL edge_resp_len got=%0d want=2", resp_q.size()); end
    while (resp_q.size() < 2) resp_q.push_back('{-1, 8'h00, 1'b0, 1'b0});
    total++;
    if (resp_q[0].port != 0 || resp_q[0].data !== 8'hD0 || resp_q[1].data !== 8'hD1 || resp_q[1].last !== 1'b1) begin
      bad++;
      $display("FAIL edge_resp got=p%0d/%h/%h want=p0/d0/d1", resp_q[0].port, resp_q[0].data, resp_q[1].data);
    end
  endtask

  task automatic test_backpressure();
    int base;
    clear();
    base = req_pkts;
    dn_mode = 1;
    bp_en = 1'b1;
    fork
      send_req(1, 8, 8'h80, 1'b1);
      begin wait_req(base + 1); tick(); send_resp(8, 8'hE0, 1'b1); end
    join
    dn_mode = 0;
    bp_en = 1'b0;
    repeat (3) tick();
    total++;
    if (req_q.size() !== 8 || resp_q.size() !== 8) begin
      bad++; $display("FAIL bp_len got=%0d/%0d want=8/8", req_q.size(), resp_q.size());
    end
    while (req_q.size() < 8) req_q.push_back('{-1, 8'h00, 1'b0, 1'b0});
    while (resp_q.size() < 8) resp_q.push_back('{-1, 8'h00, 1'b0, 1'b0});
    for (int b = 0; b < 8; b++) begin
      total++;
      if (req_q[b].data !== 8'h80 + 8'(b) || req_q[b].last !== (b == 7) || req_q[b].user !== (b == 7) || req_q[b].port != 1) begin
        bad++;
        $display("FAIL bp_req%0d got=%h/%b/%b want=%h/%b/%b", b, req_q[b].data, req_q[b].last, req_q[b].user, 8'h80 + 8'(b), (b == 7), (b == 7));
      end
      total++;
      if (resp_q[b].data !== 8'hE0 + 8'(b) || resp_q[b].user !== (b == 7) || resp_q[b].port != 1) begin
        bad++;
        $display("FAIL bp_resp%0d got=%h/%b/p%0d want=%h/%b/p1", b, resp_q[b].data, resp_q[b].user, resp_q[b].port, 8'hE0 + 8'(b), (b == 7));
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    send_req(0, 2, 8'h11, 1'b0);
    for (int b = 0; b < 2; b++) begin
      int t;
      bus.down_xfcp_in_tdata  = 8'hF0 + 8'(b);
      bus.down_xfcp_in_tvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!bus.down_xfcp_in_tready && t < 100) begin @(negedge clk); t++; end
      tick();
    end
    bus.down_xfcp_in_tdata = 8'hF2;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.down_xfcp_in_tvalid = 1'b0;
    @(negedge clk);
    total += 4;
    if (bus.up_xfcp_out_tvalid !== 3'b000) begin bad++; $display("FAIL mid_up_out_tvalid got=%b want=000", bus.up_xfcp_out_tvalid); end
    if (bus.down_xfcp_out_tvalid !== 1'b0) begin bad++; $display("FAIL mid_down_out_tvalid got=%b want=0", bus.down_xfcp_out_tvalid); end
    if (bus.up_xfcp_in_tready !== 3'b000) begin bad++; $display("FAIL mid_up_in_tready got=%b want=000", bus.up_xfcp_in_tready); end
    if (bus.down_xfcp_in_tready !== 1'b1) begin bad++; $display("FAIL mid_down_in_tready got=%b want=1", bus.down_xfcp_in_tready); end
    tick();
    clear();
    base = req_pkts;
    fork
      send_req(0, 2, 8'h21, 1'b0);
      begin wait_req(base + 1); tick(); send_resp(3, 8'h31, 1'b0); end
    join
    repeat (2) tick();
    total++;
    if (grant_q.size() !== 1 || resp_q.size() !== 3) begin
      bad++; $display("FAIL mid_after_len got=%0d/%0d want=1/3", grant_q.size(), resp_q.size());
    end
    while (resp_q.size() < 3) resp_q.push_back('{-1, 8'h00, 1'b0, 1'b0});
    total++;
    if (resp_q[0].port != 0 || resp_q[0].data !== 8'h31 || resp_q[2].data !== 8'h33 || resp_q[2].last !== 1'b1) begin
      bad++;
      $display("FAIL mid_after_resp got=p%0d/%h/%h want=p0/31/33", resp_q[0].port, resp_q[0].data, resp_q[2].data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_timeout_edge();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
